adam_aes_stream: RTL and testbench
==================================

# adam_aes_stream

Parametrised AES streaming mode controller that sits between a valid/ready block stream and an AES block engine (encipher/decipher/key expansion). It generalises single-key, single-shot control to a multi-slot key cache (NUM_KEYS) and ECB/CBC/CTR chaining modes. Results go to a parametrised output FIFO. One block is in flight at a time, and key expansion is skipped when the selected slot is already expanded and clean.

## Interface
- NUM_KEYS, 2: key slots the engine can hold; KS_W = max(1, $clog2(NUM_KEYS)).
- CTR_WIDTH, 32: low counter bits incremented in CTR mode, 1..128.
- OUT_DEPTH, 2: output FIFO depth, power of two, ≥2.
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- cfg_mode  in  2  0 ECB, 1 CBC, 2 CTR, 3 treated as ECB; sampled at input accept.
- cfg_encdec  in  1  1 encrypt, 0 decrypt; sampled at accept, ignored in CTR.
- cfg_key_sel  in  KS_W  key slot; sampled at accept.
- cfg_iv  in  128  IV/initial counter.
- cfg_iv_load  in  1  loads cfg_iv into chain_reg when busy=0, ignored otherwise.
- key_update  in  NUM_KEYS  per-slot pulse: software rewrote key i.
- in_valid/in_ready  in/out  1  input handshake.
- in_data  in  128  input block.
- out_valid/out_ready  out/in  1  output handshake (FIFO head).
- out_data  out  128  FIFO head data.
- busy  out  1  state ≠ IDLE.
- eng_key_init  out  1  one-cycle pulse: expand slot eng_key_sel.
- eng_key_ready  in  1  level: expansion complete.
- eng_start  out  1  one-cycle pulse: process eng_block.
- eng_encdec  out  1  engine direction.
- eng_key_sel  out  KS_W  slot for init/start.
- eng_block  out  128  engine input block.
- eng_done  in  1  one-cycle pulse: eng_result valid.
- eng_result  in  128  engine output.

## Operation
- FSM states: IDLE, KEY_INIT, KEY_WAIT, CIPHER, WAIT.
- IDLE:
  - in_ready = (state==IDLE) && !fifo_full.
  - On accept, capture data, mode, encdec and key_sel.
  - If !key_valid or key_sel ≠ cur_slot, go to KEY_INIT. Otherwise go to CIPHER.
- KEY_INIT: pulse eng_key_init; cur_slot ← sel; key_valid ← 0; go to KEY_WAIT.
- KEY_WAIT: when eng_key_ready=1, set key_valid ← 1 and go to CIPHER.
- CIPHER: pulse eng_start, then go to WAIT. eng_block and eng_encdec per mode:
  - ECB: data, cfg_encdec.
  - CBC encrypt: data ^ chain, 1.
  - CBC decrypt: data, 0.
  - CTR: chain, 1.
- WAIT: on eng_done, push the result to the FIFO, update chain, and go to IDLE.
  - ECB: r.
  - CBC encrypt: r; chain ← r.
  - CBC decrypt: r ^ chain; chain ← data.
  - CTR: r ^ data; chain[CTR_WIDTH-1:0] += 1 modulo 2^CTR_WIDTH; upper bits unchanged.
- key_update[cur_slot] clears key_valid. If it coincides with KEY_WAIT completion, invalidation wins. A block already in flight completes; the next block re-expands. Pulses for other slots have no effect.
- eng_key_sel is driven from the captured sel throughout the operation.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, out_data 0, busy 0, eng_key_init 0, eng_start 0, eng_block 0, chain 0, key_valid 0, cur_slot 0, FIFO empty.
- Cached-key latency: accept at T, eng_start at T+1, eng_done at D, out_valid at D+1.
- Key-miss latency: eng_key_init at T+1, KEY_WAIT from T+2, eng_start one cycle after eng_key_ready is seen.
- in_ready drops the cycle after accept. It returns in the cycle after eng_done, provided the FIFO is not full.
- FIFO overflow is impossible: fullness is checked at accept and only one block is in flight.
- FIFO pop (out_valid && out_ready) and push in the same cycle are both honoured.
- out_data holds while out_valid=1 and out_ready=0.
- Reset mid-operation returns all state to reset values immediately; an in-flight engine result is discarded.

## Structure
- Package adam_aes_pkg holds aes_mode_e (ECB/CBC/CTR), the stream_state_e enum and the AES_BLOCK_W=128 constant.
- Sub-module adam_aes_ofifo is a parametrised WIDTH/DEPTH synchronous FIFO with full/empty flags and an async reset.

## Test plan
Tests use a behavioural engine model with a 10-cycle eng_done delay.
- ECB AES-128: key 000102…0f in slot 0, in_data 00112233445566778899aabbccddeeff → out_data 69c4e0d86a7b0430d8cdb78070b4c55a, with exactly one eng_key_init.
- Key reuse and switch:
  - A second block on slot 0 → no eng_key_init, out_valid 12 cycles after accept.
  - Slot 1 → eng_key_init.
  - Back to slot 0 → eng_key_init again.
  - key_update[0] → the next slot-0 block re-inits.
- CBC: key 2b7e151628aed2a6abf7158809cf4f3c, IV 000102…0f, plaintext 6bc1bee22e409f96e93d7e117393172a → 7649abac8119b246cee98e9b12e9197d. Decrypting that ciphertext with the IV reloaded → original plaintext.
- CTR wrap: CTR_WIDTH=32, IV low word ffffffff. After one block the chain low word is 00000000 and bits 127:32 are unchanged. Re-encrypting the output recovers the input.
- Backpressure: OUT_DEPTH=2, out_ready=0. Two blocks complete, then in_ready stays 0. One pop → in_ready=1 the next cycle, and data order is preserved.
- Reset mid-WAIT and cfg_iv_load while busy: after reset, out_valid=0, in_ready=1 and chain=0. cfg_iv_load during WAIT leaves chain unchanged.

Source files
------------

// File: rtl/adam_aes_pkg.sv
// Shared types and constants for the AES streaming controller.
// Latency: none (declarations only).
// Backpressure: not applicable.
package adam_aes_pkg;

    localparam int AES_BLOCK_W = 128;

    typedef enum logic [1:0] {
        MODE_ECB = 2'd0,
        MODE_CBC = 2'd1,
        MODE_CTR = 2'd2
    } aes_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_KEY_INIT = 3'd1,
        ST_KEY_WAIT = 3'd2,
        ST_CIPHER   = 3'd3,
        ST_WAIT     = 3'd4
    } stream_state_e;

    // The unused mode encoding falls back to ECB.
    function automatic aes_mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'd1:    return MODE_CBC;
            2'd2:    return MODE_CTR;
            default: return MODE_ECB;
        endcase
    endfunction

endpackage

// File: rtl/adam_aes_ofifo.sv
// Synchronous FIFO holding finished cipher blocks.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty; push and pop may share a cycle.
module adam_aes_ofifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // Storage is cleared on reset so the head reads zero when empty after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // Pointers carry an extra wrap bit to tell full from empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

endmodule

// File: rtl/adam_aes_stream.sv
// AES stream controller: ECB/CBC/CTR chaining around a block engine with a key-slot cache.
// Latency: cached key accept->eng_start 1 cycle, eng_done->out_valid 1 cycle; a key miss adds expansion time.
// Backpressure: one block in flight; in_ready only in IDLE with room in the output FIFO.
module adam_aes_stream
    import adam_aes_pkg::*;
#(
    parameter int NUM_KEYS  = 2,
    parameter int CTR_WIDTH = 32,
    parameter int OUT_DEPTH = 2,
    localparam int KS_W     = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [1:0]             cfg_mode,
    input  logic                   cfg_encdec,
    input  logic [KS_W-1:0]        cfg_key_sel,
    input  logic [AES_BLOCK_W-1:0] cfg_iv,
    input  logic                   cfg_iv_load,
    input  logic [NUM_KEYS-1:0]    key_update,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BLOCK_W-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] out_data,
    output logic                   busy,
    output logic                   eng_key_init,
    input  logic                   eng_key_ready,
    output logic                   eng_start,
    output logic                   eng_encdec,
    output logic [KS_W-1:0]        eng_key_sel,
    output logic [AES_BLOCK_W-1:0] eng_block,
    input  logic                   eng_done,
    input  logic [AES_BLOCK_W-1:0] eng_result
);
    // Only the low CTR_WIDTH bits of the counter advance; upper IV bits stay fixed.
    localparam logic [AES_BLOCK_W-1:0] CTR_MASK = {AES_BLOCK_W{1'b1}} >> (AES_BLOCK_W - CTR_WIDTH);
    localparam logic [AES_BLOCK_W-1:0] ONE      = 1;

    stream_state_e          state;
    logic [AES_BLOCK_W-1:0] data_q;
    logic [AES_BLOCK_W-1:0] chain;
    logic [AES_BLOCK_W-1:0] chain_next;
    logic [AES_BLOCK_W-1:0] push_data;
    aes_mode_e              mode_q;
    logic                   encdec_q;
    logic [KS_W-1:0]        sel_q;
    logic [KS_W-1:0]        cur_slot;
    logic                   key_valid;
    logic                   cur_invalidated;
    logic                   key_hit;
    logic                   accept;
    logic                   push;
    logic                   fifo_full;
    logic                   fifo_empty;

    assign accept          = in_valid && in_ready;
    assign cur_invalidated = key_update[cur_slot];
    // A rewrite of the expanded slot in the accept cycle already counts as a miss.
    assign key_hit         = key_valid && !cur_invalidated && (cfg_key_sel == cur_slot);
    assign push            = (state == ST_WAIT) && eng_done;

    assign in_ready     = (state == ST_IDLE) && !fifo_full;
    assign busy         = (state != ST_IDLE);
    assign eng_key_init = (state == ST_KEY_INIT);
    assign eng_start    = (state == ST_CIPHER);
    assign eng_key_sel  = sel_q;
    assign eng_encdec   = (mode_q == MODE_CTR) || encdec_q;
    assign out_valid    = !fifo_empty;

    // Engine input block: CBC encrypt whitens with the chain, CTR ciphers the counter.
    always_comb begin
        eng_block = data_q;
        case (mode_q)
            MODE_CBC: if (encdec_q) eng_block = data_q ^ chain;
            MODE_CTR: eng_block = chain;
            default:  eng_block = data_q;
        endcase
    end

    // Output block and next chain value from the engine result.
    always_comb begin
        push_data  = eng_result;
        chain_next = chain;
        case (mode_q)
            MODE_CBC: begin
                if (encdec_q) begin
                    chain_next = eng_result;
                end else begin
                    push_data  = eng_result ^ chain;
                    chain_next = data_q;
                end
            end
            MODE_CTR: begin
                push_data  = eng_result ^ data_q;
                chain_next = (chain & ~CTR_MASK) | ((chain + ONE) & CTR_MASK);
            end
            default: push_data = eng_result;
        endcase
    end

    // Control FSM with key-slot tracking and chain register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            data_q    <= '0;
            mode_q    <= MODE_ECB;
            encdec_q  <= 1'b0;
            sel_q     <= '0;
            cur_slot  <= '0;
            key_valid <= 1'b0;
            chain     <= '0;
        end else begin
            if (cur_invalidated) key_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cfg_iv_load) chain <= cfg_iv;
                    if (accept) begin
                        data_q   <= in_data;
                        mode_q   <= decode_mode(cfg_mode);
                        encdec_q <= cfg_encdec;
                        sel_q    <= cfg_key_sel;
                        state    <= key_hit ? ST_CIPHER : ST_KEY_INIT;
                    end
                end
                ST_KEY_INIT: begin
                    cur_slot  <= sel_q;
                    key_valid <= 1'b0;
                    state     <= ST_KEY_WAIT;
                end
                ST_KEY_WAIT: begin
                    // A rewrite landing on completion leaves the slot stale; this block still runs.
                    if (eng_key_ready) begin
                        if (!cur_invalidated) key_valid <= 1'b1;
                        state <= ST_CIPHER;
                    end
                end
                ST_CIPHER: state <= ST_WAIT;
                ST_WAIT: begin
                    if (eng_done) begin
                        chain <= chain_next;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    adam_aes_ofifo #(
        .WIDTH (AES_BLOCK_W),
        .DEPTH (OUT_DEPTH)
    ) u_ofifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_data),
        .pop       (out_valid && out_ready),
        .pop_data  (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_adam_aes_stream.sv
// Bench for adam_aes_stream with an AES-128 engine model and a chaining reference model.
// Latency: engine result 10 cycles after eng_start, key expansion ready 3 cycles after init.
// Backpressure: out_ready held low except while the bench pops one block.
module tb_adam_aes_stream;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [1:0]   cfg_mode;
    logic         cfg_encdec;
    logic [0:0]   cfg_key_sel;
    logic [127:0] cfg_iv;
    logic         cfg_iv_load;
    logic [1:0]   key_update;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;
    logic         eng_key_init;
    logic         eng_key_ready = 1'b0;
    logic         eng_start;
    logic         eng_encdec;
    logic [0:0]   eng_key_sel;
    logic [127:0] eng_block;
    logic         eng_done = 1'b0;
    logic [127:0] eng_result = '0;

    always #5 clk = ~clk;

    adam_aes_stream #(.NUM_KEYS(2), .CTR_WIDTH(32), .OUT_DEPTH(2)) dut (
        .clk(clk), .reset_n(reset_n), .cfg_mode(cfg_mode), .cfg_encdec(cfg_encdec),
        .cfg_key_sel(cfg_key_sel), .cfg_iv(cfg_iv), .cfg_iv_load(cfg_iv_load),
        .key_update(key_update), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy),
        .eng_key_init(eng_key_init), .eng_key_ready(eng_key_ready), .eng_start(eng_start),
        .eng_encdec(eng_encdec), .eng_key_sel(eng_key_sel), .eng_block(eng_block),
        .eng_done(eng_done), .eng_result(eng_result)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int kinit_cnt = 0;
    logic [127:0] key_mem [2];
    logic [127:0] ref_chain;
    logic [7:0]   sb [256];
    logic [7:0]   isb [256];

    // ---------------- AES-128 reference functions ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00; x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv ? isb[s[127-8*i -: 8]] : sb[s[127-8*i -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        int src;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                src = inv ? (c - r + 4) % 4 : (c + r) % 4;
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*src+r) -: 8];
            end
        return o;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        logic [7:0]   m [4];
        logic [7:0]   acc;
        if (inv) m = '{8'd14, 8'd11, 8'd13, 8'd9};
        else     m = '{8'd2, 8'd3, 8'd1, 8'd1};
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) acc ^= gmul(m[(j - r + 4) % 4], s[127-8*(4*c+j) -: 8]);
                o[127-8*(4*c+r) -: 8] = acc;
            end
        return o;
    endfunction

    function automatic logic [10:0][127:0] kexp(input logic [127:0] k);
        logic [10:0][127:0] rk;
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return rk;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] p);
        logic [10:0][127:0] rk;
        logic [127:0] s;
        rk = kexp(k);
        s = p ^ rk[0];
        for (int r = 1; r < 10; r++) s = mix_cols(shift_rows(sub_bytes(s, 0), 0), 0) ^ rk[r];
        return shift_rows(sub_bytes(s, 0), 0) ^ rk[10];
    endfunction

    function automatic logic [127:0] aes_dec(input logic [127:0] k, input logic [127:0] c);
        logic [10:0][127:0] rk;
        logic [127:0] s;
        rk = kexp(k);
        s = c ^ rk[10];
        for (int r = 9; r >= 1; r--) s = mix_cols(sub_bytes(shift_rows(s, 1), 1) ^ rk[r], 1);
        return sub_bytes(shift_rows(s, 1), 1) ^ rk[0];
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- engine model and event counters ----------------
    logic [127:0] ekey = '0;
    logic [127:0] e_blk = '0;
    logic         e_dir = 1'b0;
    int           kcnt = 0;
    int           ecnt = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (eng_key_init) kinit_cnt <= kinit_cnt + 1;
    end

    // The engine ignores controller reset so a result in flight still pulses afterwards.
    always @(posedge clk) begin
        eng_done <= 1'b0;
        if (eng_key_init) begin
            ekey <= key_mem[eng_key_sel];
            kcnt <= 3;
            eng_key_ready <= 1'b0;
        end else if (kcnt != 0) begin
            kcnt <= kcnt - 1;
            if (kcnt == 1) eng_key_ready <= 1'b1;
        end
        if (eng_start) begin
            e_blk <= eng_block;
            e_dir <= eng_encdec;
            ecnt  <= 9;
        end else if (ecnt != 0) begin
            ecnt <= ecnt - 1;
            if (ecnt == 1) begin
                eng_done   <= 1'b1;
                eng_result <= e_dir ? aes_enc(ekey, e_blk) : aes_dec(ekey, e_blk);
            end
        end
    end

    // ---------------- checking and stimulus helpers ----------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Chaining modes applied to whole blocks, tracking the running chain value.
    task automatic model(input logic [127:0] d, input logic [1:0] mode, input logic ed,
                         input int sel, output logic [127:0] exp);
        logic [127:0] k;
        k = key_mem[sel];
        case (mode)
            2'd1: begin
                if (ed) begin exp = aes_enc(k, d ^ ref_chain); ref_chain = exp; end
                else    begin exp = aes_dec(k, d) ^ ref_chain; ref_chain = d; end
            end
            2'd2: begin
                exp = aes_enc(k, ref_chain) ^ d;
                ref_chain[31:0] = ref_chain[31:0] + 32'd1;
            end
            default: exp = ed ? aes_enc(k, d) : aes_dec(k, d);
        endcase
    endtask

    task automatic send(input logic [127:0] d, input logic [1:0] mode, input logic ed,
                        input int sel, output int acc);
        int n;
        n = 0;
        @(negedge clk);
        in_data = d; cfg_mode = mode; cfg_encdec = ed; cfg_key_sel = sel[0]; in_valid = 1'b1;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        chk("send_wait_ok", 128'(n < 100), 128'd1);
        @(posedge clk);
        acc = cyc;
        #1 in_valid = 1'b0;
        chk("in_ready_drop", 128'(in_ready), 128'd0);
        chk("busy_after_accept", 128'(busy), 128'd1);
    endtask

    task automatic recv(output logic [127:0] d, output int at);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 200) begin @(negedge clk); n++; end
        chk("recv_wait_ok", 128'(n < 200), 128'd1);
        at = cyc;
        d = out_data;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin @(negedge clk); n++; end
        chk("idle_wait_ok", 128'(n < 100), 128'd1);
    endtask

    task automatic load_iv(input logic [127:0] v);
        @(negedge clk);
        cfg_iv = v; cfg_iv_load = 1'b1;
        @(negedge clk);
        cfg_iv_load = 1'b0;
        ref_chain = v;
    endtask

    task automatic block(input logic [127:0] d, input logic [1:0] mode, input logic ed,
                         input int sel, input string tag, output logic [127:0] got, output int lat);
        logic [127:0] exp;
        int acc, at;
        model(d, mode, ed, sel, exp);
        send(d, mode, ed, sel, acc);
        recv(got, at);
        lat = at - acc;
        chk({tag, "_data"}, got, exp);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed and random sequence ----------------
    initial begin
        logic [127:0] got, got2, exp1, exp2, d1, d2, iv, c1;
        logic         seen;
        int           lat, k0, acc, at;

        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv, r1, r2, r3, r4;
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            r1 = {inv[6:0], inv[7]}; r2 = {r1[6:0], r1[7]}; r3 = {r2[6:0], r2[7]}; r4 = {r3[6:0], r3[7]};
            sb[x] = inv ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
            isb[sb[x]] = 8'(x);
        end

        reset_n = 1'b0; in_valid = 1'b0; in_data = '0; cfg_mode = 2'd0; cfg_encdec = 1'b0;
        cfg_key_sel = 1'b0; cfg_iv = '0; cfg_iv_load = 1'b0; key_update = 2'b00; out_ready = 1'b0;
        key_mem[0] = 128'h000102030405060708090a0b0c0d0e0f;
        key_mem[1] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        ref_chain = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_out_data", out_data, 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_key_init", 128'(eng_key_init), 128'd0);
        chk("rst_start", 128'(eng_start), 128'd0);
        chk("rst_eng_block", eng_block, 128'd0);
        reset_n = 1'b1;

        // ECB known answer on a cold key
        k0 = kinit_cnt;
        block(128'h00112233445566778899aabbccddeeff, 2'd0, 1'b1, 0, "ecb_kat", got, lat);
        chk("ecb_kat_value", got, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        chk("ecb_kat_inits", 128'(kinit_cnt - k0), 128'd1);
        chk("miss_latency", 128'(lat), 128'd17);

        // Cached key, then slot switches
        k0 = kinit_cnt;
        block(rand128(), 2'd0, 1'b1, 0, "ecb_reuse", got, lat);
        chk("reuse_inits", 128'(kinit_cnt - k0), 128'd0);
        chk("hit_latency", 128'(lat), 128'd12);
        k0 = kinit_cnt;
        block(rand128(), 2'd3, 1'b0, 1, "mode3_dec_slot1", got, lat);
        chk("slot1_inits", 128'(kinit_cnt - k0), 128'd1);
        k0 = kinit_cnt;
        block(rand128(), 2'd0, 1'b1, 0, "back_slot0", got, lat);
        chk("back_slot0_inits", 128'(kinit_cnt - k0), 128'd1);

        // Rewrites: another slot has no effect, the active slot forces re-expansion
        @(negedge clk) key_update = 2'b10;
        @(negedge clk) key_update = 2'b00;
        k0 = kinit_cnt;
        block(rand128(), 2'd0, 1'b1, 0, "other_update", got, lat);
        chk("other_update_inits", 128'(kinit_cnt - k0), 128'd0);
        key_mem[0] = rand128();
        @(negedge clk) key_update = 2'b01;
        @(negedge clk) key_update = 2'b00;
        k0 = kinit_cnt;
        block(rand128(), 2'd0, 1'b1, 0, "own_update", got, lat);
        chk("own_update_inits", 128'(kinit_cnt - k0), 128'd1);

        // CBC known answer, a chained block, then decrypt with the IV reloaded
        load_iv(128'h000102030405060708090a0b0c0d0e0f);
        block(128'h6bc1bee22e409f96e93d7e117393172a, 2'd1, 1'b1, 1, "cbc_enc", got, lat);
        chk("cbc_enc_kat", got, 128'h7649abac8119b246cee98e9b12e9197d);
        block(rand128(), 2'd1, 1'b1, 1, "cbc_chained", got, lat);
        load_iv(128'h000102030405060708090a0b0c0d0e0f);
        block(128'h7649abac8119b246cee98e9b12e9197d, 2'd1, 1'b0, 1, "cbc_dec", got, lat);
        chk("cbc_dec_kat", got, 128'h6bc1bee22e409f96e93d7e117393172a);

        // CTR counter wrap in the low word
        iv = {rand128() >> 32, 32'hffffffff};
        load_iv(iv);
        d1 = rand128();
        block(d1, 2'd2, 1'b1, 0, "ctr_first", c1, lat);
        d2 = rand128();
        block(d2, 2'd2, 1'b0, 0, "ctr_second", got, lat);
        chk("ctr_wrap", got, aes_enc(key_mem[0], {iv[127:32], 32'h0}) ^ d2);
        load_iv(iv);
        block(c1, 2'd2, 1'b1, 0, "ctr_roundtrip", got, lat);
        chk("ctr_recover", got, d1);

        // IV load while busy is ignored
        load_iv(rand128());
        d1 = rand128();
        model(d1, 2'd2, 1'b1, 0, exp1);
        send(d1, 2'd2, 1'b1, 0, acc);
        repeat (4) @(negedge clk);
        chk("ivload_busy", 128'(busy), 128'd1);
        cfg_iv = rand128(); cfg_iv_load = 1'b1;
        @(negedge clk) cfg_iv_load = 1'b0;
        recv(got, at);
        chk("ivload_busy_data", got, exp1);
        block(rand128(), 2'd2, 1'b1, 0, "ivload_next", got, lat);

        // Backpressure: fill the FIFO, hold, then pop one
        d1 = rand128(); d2 = rand128();
        model(d1, 2'd0, 1'b1, 0, exp1);
        send(d1, 2'd0, 1'b1, 0, acc);
        wait_idle();
        model(d2, 2'd0, 1'b1, 0, exp2);
        send(d2, 2'd0, 1'b1, 0, acc);
        wait_idle();
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (in_ready || !out_valid || out_data !== exp1) seen = 1'b1;
        end
        chk("full_hold", 128'(seen), 128'd0);
        recv(got, at);
        chk("bp_first", got, exp1);
        chk("bp_ready_after_pop", 128'(in_ready), 128'd1);
        recv(got2, at);
        chk("bp_second", got2, exp2);

        // Reset in WAIT discards the result and clears the chain
        send(rand128(), 2'd0, 1'b1, 0, acc);
        repeat (5) @(negedge clk);
        chk("pre_reset_busy", 128'(busy), 128'd1);
        reset_n = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        ref_chain = '0;
        chk("post_reset_in_ready", 128'(in_ready), 128'd1);
        chk("post_reset_busy", 128'(busy), 128'd0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid || !in_ready) seen = 1'b1;
        end
        chk("post_reset_quiet", 128'(seen), 128'd0);
        k0 = kinit_cnt;
        d1 = rand128();
        block(d1, 2'd2, 1'b1, 0, "post_reset_ctr", got, lat);
        chk("post_reset_chain0", got, aes_enc(key_mem[0], 128'd0) ^ d1);
        chk("post_reset_inits", 128'(kinit_cnt - k0), 128'd1);

        // Randomised mix of modes, slots and IV reloads
        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 3) == 0) load_iv(rand128());
            block(rand128(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 1)), "random", got, lat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
